// File: rtl/pipe_write_sink.sv
// Responder end of the DATA/ADDR write pipeline.
// Accepted beats go into a 2-entry skid FIFO. Each pop commits the beat to an
// addressable store, bumps the commit count and folds DATA into a running XOR.
// done latches after NUM_TXN commits and freezes the sink until reset.
// rd_data is a registered read-back with read-before-write behaviour.
module pipe_write_sink #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int NUM_TXN = 16,
    localparam int CNT_W  = $clog2(NUM_TXN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    output logic              ready,
    input  logic [DATA_W-1:0] DATA,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              sink_en,
    output logic [CNT_W-1:0]  count,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              rel_q;
    logic [1:0]        occ_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [DATA_W-1:0] fifo_data [2];
    logic [ADDR_W-1:0] fifo_addr [2];
    logic [DATA_W-1:0] store [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_addr;

    // Handshake and drain qualifiers; nothing moves once done is set.
    always_comb begin
        ready     = rel_q && (occ_q < 2'd2) && !done;
        push      = valid && ready;
        pop       = sink_en && (occ_q != 2'd0) && !done;
        head_data = fifo_data[rd_ptr_q];
        head_addr = fifo_addr[rd_ptr_q];
    end

    // Holds ready low through the cycle in which reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // FIFO payload; contents are only meaningful while occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= DATA;
            fifo_addr[wr_ptr_q] <= ADDR;
        end
    end

    // Commit bookkeeping: count, sticky done and running XOR checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            done     <= 1'b0;
            checksum <= '0;
        end else if (pop) begin
            count    <= count + 1'b1;
            checksum <= checksum ^ head_data;
            if (count == CNT_W'(NUM_TXN - 1)) begin
                done <= 1'b1;
            end
        end
    end

    // Store write on commit; data survives reset, the written bits do not.
    always_ff @(posedge clk) begin
        if (pop) begin
            store[head_addr] <= head_data;
        end
    end

    // Per-entry written flags so unwritten locations read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else if (pop) begin
            written_q[head_addr] <= 1'b1;
        end
    end

    // Registered read-back; a same-edge commit is not visible until next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= written_q[rd_addr] ? store[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_pipe_write_sink.sv
// Bench for pipe_write_sink: directed table rows, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_pipe_write_sink;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int NUM_TXN = 16;
    localparam int CNT_W   = $clog2(NUM_TXN + 1);
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              in_se = 1'b0;
    logic [CNT_W-1:0]  count;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W-1:0] in_rd_addr = '0;
    logic [DATA_W-1:0] rd_data;

    always #5 clk = ~clk;

    pipe_write_sink #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TXN(NUM_TXN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (in_valid),
        .ready    (ready),
        .DATA     (in_data),
        .ADDR     (in_addr),
        .sink_en  (in_se),
        .count    (count),
        .done     (done),
        .checksum (checksum),
        .rd_addr  (in_rd_addr),
        .rd_data  (rd_data)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
    } beat_t;

    beat_t             mq[$];
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_wr  [DEPTH];
    int                m_cnt;
    bit                m_done;
    logic [DATA_W-1:0] m_cs;
    logic [DATA_W-1:0] m_rd;
    bit                m_rel;
    bit                last_acc;

    int vectors     = 0;
    int miscompares = 0;

    function automatic bit m_ready();
        return m_rel && (mq.size() < 2) && !m_done;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
        m_cnt    = 0;
        m_done   = 1'b0;
        m_cs     = '0;
        m_rd     = '0;
        m_rel    = 1'b0;
        last_acc = 1'b0;
    endtask

    task automatic model_step();
        bit                rdy;
        logic [DATA_W-1:0] nrd;
        beat_t             b;
        last_acc = 1'b0;
        if (!rst_n) return;
        rdy      = m_ready();
        last_acc = in_valid && rdy;
        nrd      = m_wr[in_rd_addr] ? m_mem[in_rd_addr] : '0;
        if (in_se && mq.size() > 0 && !m_done) begin
            b = mq.pop_front();
            m_mem[b.a] = b.d;
            m_wr[b.a]  = 1'b1;
            m_cnt++;
            m_cs = m_cs ^ b.d;
            if (m_cnt == NUM_TXN) m_done = 1'b1;
        end
        if (last_acc) begin
            b.d = in_data;
            b.a = in_addr;
            mq.push_back(b);
        end
        m_rel = 1'b1;
        m_rd  = nrd;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("ready", 32'(ready), 32'(m_ready()));
        cmp("count", 32'(count), 32'(m_cnt));
        cmp("done", 32'(done), 32'(m_done));
        cmp("checksum", 32'(checksum), 32'(m_cs));
        cmp("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_model();
        tick();
        tick();
        rst_n = 1'b1;
        cmp("ready_release_cycle", 32'(ready), 32'd0);
        tick();
    endtask

    // Sixteen back-to-back beats ADDR=i, DATA=A0+i with the drain enabled.
    task automatic run16();
        int i = 0;
        int t = 0;
        int acc16 = -100;
        int done_t = -1;
        in_se = 1'b1;
        while (!m_done && t < 80) begin
            in_valid = (i < NUM_TXN);
            in_data  = 8'(8'hA0 + i);
            in_addr  = 4'(i);
            tick();
            t++;
            if (last_acc) begin
                if (i == NUM_TXN - 1) acc16 = t;
                i++;
            end
            if (m_done && done_t < 0) done_t = t;
        end
        in_valid = 1'b0;
        cmp("run16_done", 32'(done), 32'd1);
        cmp("run16_done_latency", 32'(done_t - acc16), 32'd1);
        cmp("run16_count", 32'(count), 32'(NUM_TXN));
        cmp("run16_ready_after_done", 32'(ready), 32'd0);
        cmp("run16_checksum", 32'(checksum), 32'h00);
        in_rd_addr = 4'd5;
        tick();
        cmp("run16_read5", 32'(rd_data), 32'hA5);
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        tick();
        cmp("run16_count_saturated", 32'(count), 32'(NUM_TXN));
        in_valid = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        logic              se;
        logic [ADDR_W-1:0] ra;
        logic              e_rdy;
        logic [CNT_W-1:0]  e_cnt;
        logic [DATA_W-1:0] e_cs;
        logic [DATA_W-1:0] e_rd;
    } vec_t;

    vec_t tbl[10];

    task automatic run_rows(input int s, input int e);
        for (int k = s; k < e; k++) begin
            in_valid   = tbl[k].v;
            in_data    = tbl[k].d;
            in_addr    = tbl[k].a;
            in_se      = tbl[k].se;
            in_rd_addr = tbl[k].ra;
            tick();
            cmp($sformatf("row%0d_ready", k), 32'(ready), 32'(tbl[k].e_rdy));
            cmp($sformatf("row%0d_count", k), 32'(count), 32'(tbl[k].e_cnt));
            cmp($sformatf("row%0d_checksum", k), 32'(checksum), 32'(tbl[k].e_cs));
            cmp($sformatf("row%0d_rd_data", k), 32'(rd_data), 32'(tbl[k].e_rd));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Stalled drain: two accepts fill the FIFO, third beat is held, then
        // all three commit in order once sink_en rises.
        tbl[0] = '{1'b1, 8'h10, 4'd1, 1'b0, 4'd0, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 8'h20, 4'd2, 1'b0, 4'd0, 1'b0, 5'd0, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 8'h34, 4'd7, 1'b0, 4'd0, 1'b0, 5'd0, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 8'h34, 4'd7, 1'b1, 4'd0, 1'b1, 5'd1, 8'h10, 8'h00};
        tbl[4] = '{1'b1, 8'h34, 4'd7, 1'b1, 4'd0, 1'b1, 5'd2, 8'h30, 8'h00};
        tbl[5] = '{1'b0, 8'h00, 4'd0, 1'b1, 4'd1, 1'b1, 5'd3, 8'h04, 8'h10};
        // Duplicate address 3: same-edge read returns the older value.
        tbl[6] = '{1'b1, 8'h11, 4'd3, 1'b1, 4'd3, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[7] = '{1'b1, 8'h22, 4'd3, 1'b1, 4'd3, 1'b1, 5'd1, 8'h11, 8'h00};
        tbl[8] = '{1'b0, 8'h00, 4'd0, 1'b1, 4'd3, 1'b1, 5'd2, 8'h33, 8'h11};
        tbl[9] = '{1'b0, 8'h00, 4'd0, 1'b1, 4'd3, 1'b1, 5'd2, 8'h33, 8'h22};

        model_reset();
        cmp("reset_ready", 32'(ready), 32'd0);

        apply_reset();
        cmp("reset_count", 32'(count), 32'd0);
        cmp("reset_done", 32'(done), 32'd0);
        run16();

        apply_reset();
        run_rows(0, 6);
        apply_reset();
        run_rows(6, 10);

        // Occupancy held at 1 by simultaneous push and pop.
        apply_reset();
        in_valid = 1'b1; in_data = 8'h50; in_addr = 4'd0; in_se = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h51 + k);
            in_addr  = 4'(k + 1);
            in_se    = 1'b1;
            tick();
            cmp("pushpop_ready", 32'(ready), 32'd1);
            cmp("pushpop_count", 32'(count), 32'(k + 1));
        end
        in_valid = 1'b0;

        // Never-written address reads zero.
        apply_reset();
        in_rd_addr = 4'd9;
        tick();
        cmp("read_unwritten9", 32'(rd_data), 32'd0);

        // Reset with 7 commits done and 2 beats buffered.
        begin
            int bi = 0;
            int t  = 0;
            while (!(m_cnt == 7 && mq.size() == 2) && t < 40) begin
                in_se    = (m_cnt < 7);
                in_valid = (m_cnt + mq.size() < 9);
                in_data  = 8'(8'h60 + bi);
                in_addr  = 4'(bi);
                tick();
                t++;
                if (last_acc) bi++;
            end
            cmp("midreset_setup_count", 32'(count), 32'd7);
        end
        in_se = 1'b0;
        in_rd_addr = 4'd0;
        apply_reset();
        cmp("midreset_count", 32'(count), 32'd0);
        cmp("midreset_done", 32'(done), 32'd0);
        cmp("midreset_checksum", 32'(checksum), 32'd0);
        tick();
        cmp("midreset_read0", 32'(rd_data), 32'd0);
        run16();

        // Randomized traffic; the driver holds a beat until it is taken.
        for (int ep = 0; ep < 5; ep++) begin
            apply_reset();
            for (int c = 0; c < 70; c++) begin
                if (!(in_valid && !last_acc)) begin
                    in_valid = ($urandom_range(3) != 0);
                    in_data  = 8'($urandom);
                    in_addr  = 4'($urandom);
                end
                in_se      = ($urandom_range(9) < 7);
                in_rd_addr = 4'($urandom);
                tick();
            end
            in_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_write_sink.md
Name: pipe_write_sink

Overview:
- Responder end of the DATA/ADDR write pipeline; consumes the write beats a pipelined driver issues onto the interface.
- Buffers beats in a 2-entry skid FIFO, commits them to an addressable store, and counts committed beats.
- Raises done after NUM_TXN commits so the bench can end the run.
- Exposes a registered read-back port for scoreboard checks.

Parameters:
- DATA_W, 8, width of the DATA beat.
- ADDR_W, 4, width of ADDR; the store has 2**ADDR_W entries.
- NUM_TXN, 16, commits required before done; count width CNT_W = $clog2(NUM_TXN+1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- valid  input  1  a write beat is presented on DATA/ADDR.
- ready  output  1  sink accepts a beat this cycle.
- DATA  input  DATA_W  write data.
- ADDR  input  ADDR_W  write address.
- sink_en  input  1  when 1, FIFO drains one entry per cycle; when 0, drain stalls.
- count  output  CNT_W  number of committed beats.
- done  output  1  count has reached NUM_TXN.
- checksum  output  DATA_W  XOR of all committed DATA.
- rd_addr  input  ADDR_W  read-back address.
- rd_data  output  DATA_W  registered read-back data.

Behaviour:
- Reset: rst_n low asynchronously clears FIFO pointers and occupancy, count, done, checksum, rd_data, and all per-entry written bits. Store data is not cleared. ready is 0 while rst_n is low and during the reset-release cycle; it follows the rule below from the first edge after release.
- Accept: a beat is accepted on a posedge where valid && ready. ready = (occupancy < 2) && !done. DATA and ADDR are sampled only on accept. valid with ready=0 is ignored; the driver holds the beat.
- FIFO: 2 entries, in-order. Push on accept; pop when sink_en && occupancy > 0. Push and pop in the same cycle leave occupancy unchanged. Push never occurs when full.
- Commit: a pop writes store[ADDR] = DATA, sets written[ADDR], increments count, and sets checksum ^= DATA, all on the same edge.
- Latency: a beat accepted at edge N into an empty FIFO with sink_en=1 commits at edge N+1. Minimum accept-to-count latency is 1 cycle. Sustained throughput is 1 beat per cycle.
- Duplicate addresses: a later commit to the same address overwrites the earlier one. count still increments per beat.
- done: set on the edge where count becomes NUM_TXN. It is sticky until reset. Once done, ready=0, no further accepts occur, and count saturates at NUM_TXN. Beats still in the FIFO at that point are not committed and are dropped.
- Read-back: rd_data at edge N+1 = store[rd_addr sampled at N] if written, else 0. A read and a commit to the same address on the same edge return the old value (read-before-write).
- Reset mid-operation: in-flight FIFO beats are discarded; count, done and checksum return to 0; unwritten reads return 0.

Test Plan:
- Reset, then 16 back-to-back beats ADDR=i, DATA=8'hA0+i with sink_en=1 -> count increments each cycle; done=1 one cycle after the 16th accept; ready=0 thereafter; read of ADDR 5 returns 8'hA5; checksum = XOR of A0..AF = 8'h00.
- sink_en=0, drive 3 beats -> ready drops after 2 accepts; 3rd beat held with count=0; raise sink_en -> all 3 commit in order over 3 cycles; count=3.
- Same-cycle push/pop with occupancy 1 for 5 cycles -> occupancy stays 1 and ready stays 1.
- Two beats ADDR=3 with DATA=8'h11 then 8'h22 -> rd_data at ADDR 3 = 8'h22; count=2; checksum=8'h33. Read of ADDR 3 on the edge of the second commit returns 8'h11.
- rst_n pulsed low after 7 commits with 2 beats buffered -> count=0, done=0, checksum=0, rd_data at ADDR 0 = 0. A fresh 16-beat run then completes normally.
- Read of a never-written ADDR 9 after reset -> rd_data=0 with 1-cycle latency.
